// File: rtl/uart_tx_buffered.sv
// 8N1 serial transmitter with a one-byte holding register ahead of the shift register.
// Latency: a byte accepted in IDLE drives the start bit on the next edge; frames run back-to-back.
// Backpressure: data_in_ready drops while the holding register is full and returns once it drains.
module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  // Keep at least one counter bit so a one-cycle-per-bit configuration still elaborates.
  localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shifter, shifter_nxt;
  logic          hold_valid, hold_valid_nxt;
  logic [7:0]    hold_data, hold_data_nxt;
  logic          serial_nxt;
  logic          busy_nxt;
  logic          bit_end;

  assign data_in_ready = !hold_valid;
  assign bit_end       = (cnt == CNT_LAST);

  // Next-state logic: holding-register accept, frame sequencing, and the look-ahead line level.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_idx_nxt    = bit_idx;
    shifter_nxt    = shifter;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    serial_nxt     = 1'b1;
    busy_nxt       = 1'b0;

    // Accept only into an empty holding register; a load never coincides with this
    // because loads require hold_valid to already be set.
    if (data_in_valid && !hold_valid) begin
      hold_valid_nxt = 1'b1;
      hold_data_nxt  = data_in;
    end

    case (state)
      IDLE: begin
        if (hold_valid) begin
          shifter_nxt    = hold_data;
          hold_valid_nxt = 1'b0;
          cnt_nxt        = '0;
          state_nxt      = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (hold_valid) begin
            // Chain straight into the next start bit with no idle gap.
            shifter_nxt    = hold_data;
            hold_valid_nxt = 1'b0;
            state_nxt      = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line and busy flag are registered, so they are derived from the next state.
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shifter_nxt[bit_idx_nxt];
      default: serial_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State registers; reset abandons any frame in flight and returns the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shifter    <= 8'd0;
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shifter    <= shifter_nxt;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;
      serial_out <= serial_nxt;
      tx_busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at 10 clocks per bit.
// Accepted bytes are queued as expectations and a line monitor decodes each frame against them.
// Frames are checked level-by-level per bit, plus timing of accepts, starts and reset.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         start_q[$];
  logic       mon_busy = 1'b0;

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out(serial_out),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // A handshake seen at a falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && data_in_valid && data_in_ready) begin
      exp_q.push_back(data_in);
      acc_q.push_back(cyc + 1);
    end
  end

  // Line monitor: decode each frame cycle by cycle and compare with the oldest expected byte.
  initial begin : mon
    logic [7:0] b;
    logic [9:0] frame;
    int         hits;
    int         busy_hits;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && serial_out === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("spurious_frame_queue", exp_q.size(), 1);
          b = 8'd0;
        end else begin
          b = exp_q.pop_front();
        end
        frame     = {1'b1, b, 1'b0};
        aborted   = 1'b0;
        busy_hits = 0;
        for (int i = 0; i < 10; i++) begin
          hits = 0;
          for (int c = 0; c < 10; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            if (serial_out === frame[i]) hits++;
            if (tx_busy === 1'b1) busy_hits++;
          end
          if (aborted) break;
          chk($sformatf("byte%02h_bit%0d_cycles", b, i), hits, 10);
        end
        if (!aborted) chk($sformatf("byte%02h_busy_cycles", b), busy_hits, 100);
        mon_busy = 1'b0;
      end
    end
  end

  // Offer a byte (called just after a rising edge) and return just after the edge that takes it.
  task automatic send(input logic [7:0] b);
    int n;
    data_in       = b;
    data_in_valid = 1'b1;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (data_in_ready) break;
      n++;
    end
    if (n >= 500) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      #1;
      if (!mon_busy && !tx_busy && data_in_ready && exp_q.size() == 0) break;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc < k && n < 5000);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad_lvl, bad_busy, bad_rdy, hi_rdy, lows;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_serial_out", serial_out, 1);
    chk("reset_ready", data_in_ready, 1);
    chk("reset_busy", tx_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle stability
    bad_lvl = 0; bad_busy = 0; bad_rdy = 0;
    repeat (1000) begin
      @(negedge clk);
      if (serial_out !== 1'b1) bad_lvl++;
      if (tx_busy !== 1'b0) bad_busy++;
      if (data_in_ready !== 1'b1) bad_rdy++;
    end
    chk("idle_line_low_cycles", bad_lvl, 0);
    chk("idle_busy_cycles", bad_busy, 0);
    chk("idle_not_ready_cycles", bad_rdy, 0);
    @(posedge clk);
    #1;

    // Single byte 0xA5
    acc_q.delete(); start_q.delete();
    send(8'hA5);
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("single_ready_low_after_accept", data_in_ready, 0);
    @(negedge clk);
    #1;
    chk("single_ready_back_high", data_in_ready, 1);
    chk("single_frame_started", start_q.size(), 1);
    if (start_q.size() == 1 && acc_q.size() == 1) begin
      chk("single_start_latency", start_q[0] - acc_q[0], 1);
      wait_until(start_q[0] + 100);
      chk("single_busy_after_frame", tx_busy, 0);
      chk("single_line_after_frame", serial_out, 1);
    end
    wait_idle();

    // Back-to-back with valid held high, third offer stalls
    acc_q.delete(); start_q.delete();
    send(8'h55);
    send(8'h0F);
    send(8'hC3);
    data_in_valid = 1'b0;
    wait_idle();
    chk("b2b_accepts", acc_q.size(), 3);
    chk("b2b_frames", start_q.size(), 3);
    if (acc_q.size() == 3 && start_q.size() == 3) begin
      chk("b2b_second_accept_gap", acc_q[1] - acc_q[0], 2);
      chk("b2b_first_latency", start_q[0] - acc_q[0], 1);
      chk("b2b_frame2_gap", start_q[1] - start_q[0], 100);
      chk("b2b_third_accept_after_load", acc_q[2] - start_q[1], 1);
      chk("b2b_frame3_gap", start_q[2] - start_q[1], 100);
    end

    // Backpressure: 0xFF offered for 50 cycles while one frame shifts and one byte is held
    acc_q.delete(); start_q.delete();
    send(8'h3C);
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(8'h96);
    data_in       = 8'hFF;
    data_in_valid = 1'b1;
    hi_rdy = 0;
    repeat (50) begin
      @(negedge clk);
      if (data_in_ready) hi_rdy++;
    end
    chk("bp_ready_high_cycles", hi_rdy, 0);
    @(posedge clk);
    #1;
    send(8'hFF);
    data_in_valid = 1'b0;
    wait_idle();
    chk("bp_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3 && start_q.size() == 3) begin
      chk("bp_ff_accept_after_load", acc_q[2] - start_q[1], 1);
      chk("bp_frame2_gap", start_q[1] - start_q[0], 100);
    end

    // Reset during DATA bit 3 of 0x00 with 0x7E held
    acc_q.delete(); start_q.delete();
    send(8'h00);
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    send(8'h7E);
    data_in_valid = 1'b0;
    if (start_q.size() > 0) begin
      wait_until(start_q[0] + 44);
      chk("mid_pre_rst_line", serial_out, 0);
      chk("mid_pre_rst_ready", data_in_ready, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_line_async", serial_out, 1);
      chk("mid_rst_ready_async", data_in_ready, 1);
      chk("mid_rst_busy_async", tx_busy, 0);
    end else begin
      chk("mid_frame_seen", start_q.size(), 1);
      rst = 1'b1;
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("post_rst_idle_bad_cycles", lows, 0);
    @(posedge clk);
    #1;
    acc_q.delete(); start_q.delete();
    send(8'h81);
    data_in_valid = 1'b0;
    wait_idle();
    chk("post_rst_frames", start_q.size(), 1);
    if (start_q.size() == 1 && acc_q.size() == 1)
      chk("post_rst_latency", start_q[0] - acc_q[0], 1);

    chk("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
